// File: rtl/omem_pkg.sv
// Shared constants, opcodes and scheduler state encoding for the output-memory
// access path between the SPEs, the output memory and the PE broadcast router.
package omem_pkg;

    localparam int NUM_SPE       = 5;
    localparam int OUTPUT_SIZE   = 21;
    localparam int OMEM_ENTRIES  = OUTPUT_SIZE * OUTPUT_SIZE;
    localparam int NUM_TIMESTEPS = 2;
    localparam int NUM_PE        = 11;
    localparam int SUM_WIDTH     = 13;
    localparam int ADDR_W        = 9;

    typedef enum logic [3:0] {
        OP_SPE_0_SEND_DATA = 4'd0,
        OP_SPE_1_SEND_DATA = 4'd1,
        OP_SPE_2_SEND_DATA = 4'd2,
        OP_SPE_3_SEND_DATA = 4'd3,
        OP_SPE_4_SEND_DATA = 4'd4,
        OP_SPE_0_REQ_DATA  = 4'd5,
        OP_SPE_1_REQ_DATA  = 4'd6,
        OP_SPE_2_REQ_DATA  = 4'd7,
        OP_SPE_3_REQ_DATA  = 4'd8,
        OP_SPE_4_REQ_DATA  = 4'd9,
        OP_TIMESTEP_DONE   = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        ARB, ISSUE, WAIT_RSP, TS_END, BCAST, DONE
    } state_e;

    typedef logic [NUM_SPE-1:0][ADDR_W-1:0] ptr_arr_t;

    // Each SPE starts on its own id and then strides by NUM_SPE through the map.
    function automatic ptr_arr_t ptr_init();
        ptr_arr_t p;
        for (int i = 0; i < NUM_SPE; i++) p[i] = ADDR_W'(i);
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// the previous winner, wrapping around.
module rr_arbiter5
    import omem_pkg::*;
#(
    parameter  int N  = NUM_SPE,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          gnt_vld_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic [N-1:0]  gnt_o
);

    int idx;

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        gnt_o     = '0;
        idx       = 0;
        // Scan farthest-first so the nearest requester after last_i overwrites.
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_i) + k) % N;
            if (req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'(idx);
            end
        end
        if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
    end

endmodule

// File: rtl/omem_access_sched.sv
// Output-memory access scheduler: round-robin SPE store/read arbitration with
// strided addressing, per-timestep store counting and end-of-timestep broadcast.
module omem_access_sched
    import omem_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_SPE-1:0]                 spe_req_valid_i,
    input  logic [NUM_SPE-1:0]                 spe_req_we_i,
    input  logic [NUM_SPE-1:0]                 spe_req_spike_i,
    input  logic [NUM_SPE-1:0][SUM_WIDTH-1:0]  spe_req_pot_i,
    output logic [NUM_SPE-1:0]                 spe_req_ready_o,
    output logic [NUM_SPE-1:0]                 spe_rsp_valid_o,
    output logic                               spe_rsp_spike_o,
    output logic                               mem_valid_o,
    output logic                               mem_we_o,
    output logic                               mem_bank_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    output logic                               mem_spike_o,
    output logic [SUM_WIDTH-1:0]               mem_pot_o,
    input  logic                               mem_ready_i,
    input  logic                               mem_rsp_valid_i,
    input  logic                               mem_rsp_spike_i,
    output logic                               bcast_valid_o,
    output logic [3:0]                         bcast_dest_o,
    output logic [3:0]                         bcast_opcode_o,
    input  logic                               bcast_ready_i,
    output logic [1:0]                         ts_cur_o,
    output logic                               all_done_o,
    output logic                               err_overrun_o
);

    localparam int GW = $clog2(NUM_SPE);
    localparam int CW = $clog2(OMEM_ENTRIES + 1);

    state_e               state_q, state_d;
    logic [GW-1:0]        gnt_q, gnt_d;
    logic [GW-1:0]        last_q, last_d;
    logic                 we_q, we_d;
    logic                 spike_q, spike_d;
    logic [SUM_WIDTH-1:0] pot_q, pot_d;
    ptr_arr_t             ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           ts_q, ts_d;
    logic [3:0]           dest_q, dest_d;
    logic                 err_q, err_d;

    logic                 arb_vld;
    logic [GW-1:0]        arb_idx;
    logic [NUM_SPE-1:0]   arb_onehot;
    logic [1:0]           ts_m1;

    rr_arbiter5 #(.N(NUM_SPE)) u_arb (
        .req_i     (spe_req_valid_i),
        .last_i    (last_q),
        .gnt_vld_o (arb_vld),
        .gnt_idx_o (arb_idx),
        .gnt_o     (arb_onehot)
    );

    assign ts_m1         = ts_q - 2'd1;
    assign ts_cur_o      = ts_q;
    assign all_done_o    = (state_q == DONE);
    assign err_overrun_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            gnt_q   <= '0;
            last_q  <= GW'(NUM_SPE - 1);
            we_q    <= 1'b0;
            spike_q <= 1'b0;
            pot_q   <= '0;
            ptr_q   <= ptr_init();
            cnt_q   <= '0;
            ts_q    <= 2'd1;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            spike_q <= spike_d;
            pot_q   <= pot_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        spike_d = spike_q;
        pot_d   = pot_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        dest_d  = dest_q;
        err_d   = err_q;

        spe_req_ready_o = '0;
        spe_rsp_valid_o = '0;
        spe_rsp_spike_o = 1'b0;
        mem_valid_o     = 1'b0;
        mem_we_o        = 1'b0;
        mem_bank_o      = 1'b0;
        mem_addr_o      = '0;
        mem_spike_o     = 1'b0;
        mem_pot_o       = '0;
        bcast_valid_o   = 1'b0;
        bcast_dest_o    = '0;
        bcast_opcode_o  = '0;

        unique case (state_q)
            ARB: begin
                if (arb_vld) begin
                    spe_req_ready_o = arb_onehot;
                    last_d          = arb_idx;
                    // A store past the end of the map is acknowledged but dropped.
                    if (spe_req_we_i[arb_idx] && (ptr_q[arb_idx] > ADDR_W'(OMEM_ENTRIES - 1))) begin
                        err_d = 1'b1;
                    end else begin
                        gnt_d   = arb_idx;
                        we_d    = spe_req_we_i[arb_idx];
                        spike_d = spe_req_spike_i[arb_idx];
                        pot_d   = spe_req_pot_i[arb_idx];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mem_valid_o = 1'b1;
                mem_we_o    = we_q;
                mem_bank_o  = we_q ? ts_m1[0] : 1'b0;
                mem_addr_o  = ptr_q[gnt_q];
                mem_spike_o = we_q & spike_q;
                mem_pot_o   = we_q ? pot_q : '0;
                if (mem_ready_i) begin
                    if (we_q) begin
                        ptr_d[gnt_q] = ptr_q[gnt_q] + ADDR_W'(NUM_SPE);
                        cnt_d        = cnt_q + CW'(1);
                        state_d      = (cnt_q == CW'(OMEM_ENTRIES - 1)) ? TS_END : ARB;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    spe_rsp_valid_o[gnt_q] = 1'b1;
                    spe_rsp_spike_o        = mem_rsp_spike_i;
                    state_d                = ARB;
                end
            end
            TS_END: begin
                if (ts_q == 2'(NUM_TIMESTEPS)) begin
                    state_d = DONE;
                end else begin
                    dest_d  = '0;
                    state_d = BCAST;
                end
            end
            BCAST: begin
                bcast_valid_o  = 1'b1;
                bcast_dest_o   = dest_q;
                bcast_opcode_o = OP_TIMESTEP_DONE;
                if (bcast_ready_i) begin
                    if (dest_q == 4'(NUM_PE - 1)) begin
                        ts_d    = ts_q + 2'd1;
                        ptr_d   = ptr_init();
                        cnt_d   = '0;
                        state_d = ARB;
                    end else begin
                        dest_d = dest_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = ARB;
        endcase
    end

endmodule

// File: tb/tb_omem_access_sched.sv
// Directed bench for omem_access_sched: table of single stores, then arbitration,
// read, timestep/broadcast, done, reset-in-broadcast and overrun sequences.
module tb_omem_access_sched;
    import omem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]        req_valid, req_we, req_spike, req_ready, rsp_valid;
    logic [4:0][12:0]  req_pot;
    logic              rsp_spike, mem_valid, mem_we, mem_bank, mem_spike;
    logic [8:0]        mem_addr;
    logic [12:0]       mem_pot;
    logic              mem_ready, mem_rsp_valid, mem_rsp_spike;
    logic              bcast_valid, bcast_ready, all_done, err_overrun;
    logic [3:0]        bcast_dest, bcast_opcode;
    logic [1:0]        ts_cur;

    omem_access_sched dut (
        .clk_i(clk), .rst_ni(rst_n),
        .spe_req_valid_i(req_valid), .spe_req_we_i(req_we), .spe_req_spike_i(req_spike),
        .spe_req_pot_i(req_pot), .spe_req_ready_o(req_ready),
        .spe_rsp_valid_o(rsp_valid), .spe_rsp_spike_o(rsp_spike),
        .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_bank_o(mem_bank),
        .mem_addr_o(mem_addr), .mem_spike_o(mem_spike), .mem_pot_o(mem_pot),
        .mem_ready_i(mem_ready), .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_spike_i(mem_rsp_spike),
        .bcast_valid_o(bcast_valid), .bcast_dest_o(bcast_dest), .bcast_opcode_o(bcast_opcode),
        .bcast_ready_i(bcast_ready), .ts_cur_o(ts_cur), .all_done_o(all_done),
        .err_overrun_o(err_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          spe;
        logic [12:0] pot;
        logic        spike;
        logic [8:0]  addr;
    } wvec_t;
    wvec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_we = '0; req_spike = '0; req_pot = '0;
        mem_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_spike = 1'b0;
        bcast_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ts_cur", 32'(ts_cur), 32'd1);
        chk("rst_outputs", 32'({req_ready, rsp_valid, rsp_spike, mem_valid, mem_we, mem_bank,
                                mem_addr, mem_spike, bcast_valid, bcast_dest, bcast_opcode,
                                all_done, err_overrun}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Starts and ends at posedge+1; reports what the memory port showed in the issue cycle.
    task automatic wr(input int s, input logic [12:0] pot, input logic sp,
                      output logic acc, output logic mv, output logic mwe, output logic bk,
                      output logic [8:0] a, output logic [12:0] mp, output logic msp);
        req_valid = 5'(1 << s);
        req_we    = 5'(1 << s);
        req_spike = sp ? 5'(1 << s) : 5'd0;
        req_pot   = '0;
        req_pot[s] = pot;
        #1;
        acc = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (req_ready[s]) begin acc = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (acc) begin
            @(posedge clk); #1;
            req_valid = '0; req_we = '0; req_spike = '0; req_pot = '0;
            #1;
            mv = mem_valid; mwe = mem_we; bk = mem_bank; a = mem_addr; mp = mem_pot; msp = mem_spike;
            @(posedge clk); #1;
        end else begin
            req_valid = '0; req_we = '0; req_spike = '0; req_pot = '0;
            mv = 1'b0; mwe = 1'b0; bk = 1'b0; a = '0; mp = '0; msp = 1'b0;
        end
    endtask

    task automatic run_ts(input logic exp_bank, output int bad);
        logic acc, mv, mwe, bk, msp;
        logic [8:0]  a;
        logic [12:0] mp;
        bad = 0;
        for (int j = 0; j < 89; j++) begin
            for (int s = 0; s < 5; s++) begin
                if (s == 0 || j < 88) begin
                    wr(s, 13'(j * 7 + s), 1'(j ^ s), acc, mv, mwe, bk, a, mp, msp);
                    if (!acc || !mv || !mwe || bk !== exp_bank || a !== 9'(s + 5 * j) ||
                        mp !== 13'(j * 7 + s) || msp !== 1'(j ^ s)) bad++;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic acc, mv, mwe, bk, msp;
        logic [8:0]  a;
        logic [12:0] mp;
        int bad, hold_bad, wt;
        int got[$];

        tbl[0] = '{2, 13'd100,    1'b1, 9'd2};
        tbl[1] = '{2, 13'h1fff,   1'b0, 9'd7};
        tbl[2] = '{0, 13'd5,      1'b1, 9'd0};
        tbl[3] = '{4, 13'd4095,   1'b0, 9'd4};
        tbl[4] = '{2, 13'd1,      1'b1, 9'd12};
        tbl[5] = '{0, 13'd8191,   1'b0, 9'd5};
        tbl[6] = '{1, 13'd0,      1'b1, 9'd1};

        idle_inputs();
        do_reset();

        // single stores from the table, all in timestep 1 (bank 0)
        for (int i = 0; i < 7; i++) begin
            wr(tbl[i].spe, tbl[i].pot, tbl[i].spike, acc, mv, mwe, bk, a, mp, msp);
            chk($sformatf("tbl%0d_accept", i), 32'(acc), 32'd1);
            chk($sformatf("tbl%0d_addr", i), 32'(a), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_vld_we_bank", i), 32'({mv, mwe, bk}), 32'b110);
            chk($sformatf("tbl%0d_pot", i), 32'(mp), 32'(tbl[i].pot));
            chk($sformatf("tbl%0d_spike", i), 32'(msp), 32'(tbl[i].spike));
        end

        // round-robin order with every SPE requesting from reset
        do_reset();
        req_valid = 5'h1f; req_we = 5'h1f;
        bad = 0;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            #1;
            if (req_ready != 5'd0) begin
                if (!$onehot(req_ready)) bad++;
                for (int s = 0; s < 5; s++) if (req_ready[s]) got.push_back(s);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("arb_grant_count", 32'(got.size()), 32'd10);
        chk("arb_onehot", 32'(bad), 32'd0);
        for (int k = 0; k < got.size(); k++) chk($sformatf("arb_order%0d", k), 32'(got[k]), 32'(k % 5));

        // SPE3 read with memory stall and late response
        do_reset();
        req_valid = 5'b01000; req_we = 5'b0;
        mem_rsp_valid = 1'b1; mem_rsp_spike = 1'b1;
        #1;
        chk("rd_ready", 32'(req_ready), 32'b01000);
        chk("rsp_ignored_in_arb", 32'(rsp_valid), 32'd0);
        mem_rsp_valid = 1'b0; mem_rsp_spike = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        chk("rd_issue_vld_we_bank", 32'({mem_valid, mem_we, mem_bank}), 32'b100);
        chk("rd_issue_addr", 32'(mem_addr), 32'd3);
        @(posedge clk); #1;
        chk("rd_stall_hold", 32'({mem_valid, mem_addr}), 32'({1'b1, 9'd3}));
        mem_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 5'b00011; req_we = 5'b00011;
        bad = 0;
        repeat (3) begin
            #1;
            if (req_ready != 5'd0 || rsp_valid != 5'd0 || mem_valid) bad++;
            @(posedge clk); #1;
        end
        chk("rd_wait_quiet", 32'(bad), 32'd0);
        req_valid = '0; req_we = '0;
        mem_rsp_valid = 1'b1; mem_rsp_spike = 1'b1;
        #1;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'b01000);
        chk("rd_rsp_spike", 32'(rsp_spike), 32'd1);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0; mem_rsp_spike = 1'b0;
        #1;
        chk("rd_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        wr(3, 13'd9, 1'b0, acc, mv, mwe, bk, a, mp, msp);
        chk("rd_ptr_unchanged", 32'(a), 32'd3);

        // timestep 1: 441 stores then 11 broadcasts, dest 5 held off for two cycles
        do_reset();
        run_ts(1'b0, bad);
        chk("ts1_writes", 32'(bad), 32'd0);
        chk("ts1_end_state", 32'({bcast_valid, ts_cur, all_done}), 32'({1'b0, 2'd1, 1'b0}));
        bad = 0; hold_bad = 0;
        for (int d = 0; d < 11; d++) begin
            wt = 0;
            while (!bcast_valid && wt < 8) begin @(posedge clk); #1; wt++; end
            if (!bcast_valid || bcast_dest !== 4'(d) || bcast_opcode !== 4'd15) bad++;
            if (d == 5) begin
                repeat (2) begin
                    @(posedge clk); #1;
                    if (!bcast_valid || bcast_dest !== 4'd5 || req_ready != 5'd0) hold_bad++;
                end
            end
            bcast_ready = 1'b1;
            @(posedge clk); #1;
            bcast_ready = 1'b0;
        end
        chk("bcast_seq", 32'(bad), 32'd0);
        chk("bcast_hold_d5", 32'(hold_bad), 32'd0);
        chk("ts2_ts_cur", 32'(ts_cur), 32'd2);
        chk("bcast_ends", 32'(bcast_valid), 32'd0);

        // timestep 2: stores to bank 1, then done with no broadcast
        run_ts(1'b1, bad);
        chk("ts2_writes", 32'(bad), 32'd0);
        bad = 0;
        repeat (3) begin
            if (bcast_valid) bad++;
            @(posedge clk); #1;
        end
        chk("ts2_no_bcast", 32'(bad), 32'd0);
        chk("all_done", 32'(all_done), 32'd1);
        wr(1, 13'd3, 1'b1, acc, mv, mwe, bk, a, mp, msp);
        chk("done_no_accept", 32'({acc, mv}), 32'd0);
        chk("all_done_sticky", 32'(all_done), 32'd1);

        // asynchronous reset in the middle of a broadcast
        do_reset();
        run_ts(1'b0, bad);
        bcast_ready = 1'b1;
        wt = 0;
        while (!(bcast_valid && bcast_dest == 4'd4) && wt < 20) begin @(posedge clk); #1; wt++; end
        bcast_ready = 1'b0;
        chk("bc_reach_d4", 32'({bcast_valid, bcast_dest}), 32'({1'b1, 4'd4}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bcast", 32'({bcast_valid, bcast_dest, bcast_opcode}), 32'd0);
        chk("async_rst_ts", 32'(ts_cur), 32'd1);
        do_reset();
        wr(0, 13'd77, 1'b1, acc, mv, mwe, bk, a, mp, msp);
        chk("post_rst_addr_bank", 32'({a, bk}), 32'({9'd0, 1'b0}));

        // SPE0 owns 89 addresses; the 90th store overruns
        bad = 0;
        for (int j = 1; j < 89; j++) begin
            wr(0, 13'(j), 1'b0, acc, mv, mwe, bk, a, mp, msp);
            if (!acc || !mv || a !== 9'(5 * j)) bad++;
        end
        chk("spe0_89_writes", 32'(bad), 32'd0);
        chk("no_err_yet", 32'(err_overrun), 32'd0);
        wr(0, 13'd1, 1'b1, acc, mv, mwe, bk, a, mp, msp);
        chk("overrun_accept_drop", 32'({acc, mv}), 32'b10);
        chk("overrun_flag", 32'(err_overrun), 32'd1);
        @(posedge clk); #1;
        chk("overrun_sticky", 32'({err_overrun, mem_valid}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
